binary_mul_acc_uni: RTL and testbench

//  Downstream consumer of the 4x4 unsigned pipelined multiplier.
//  - Tags each operand pair issued to the multiplier and tracks it through a LATENCY-deep valid line.
//  - Accumulates N_TERMS products into one sum (dot-product / MAC batch).
//  - Presents the sum on a valid/ready output handshake.
//  - Throttles issue via in_ready so a batch never over-issues.

---
 rtl/binary_mul_pkg.sv | 27 ++
 rtl/binary_mul_valid_dly.sv | 48 ++++
 rtl/binary_mul_acc_uni.sv | 153 +++++++++++++++
 tb/tb_binary_mul_acc_uni.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_mul_pkg.sv
// -----------------------------------------------------------------------------
// binary_mul_pkg
// Shared definitions for the 4x4 unsigned multiplier and its downstream
// multiply-accumulate consumer: batch FSM encoding, default widths, and the
// multiplier pipeline latency used by both the RTL and the benches.
// -----------------------------------------------------------------------------
package binary_mul_pkg;

  // Pipeline depth of the upstream multiplier, in en-qualified clk cycles.
  localparam int MUL_LATENCY = 5;

  // Default datapath widths.
  localparam int DEF_P_W     = 8;   // 4x4 unsigned product
  localparam int DEF_ACC_W   = 12;  // batch sum
  localparam int DEF_N_TERMS = 16;  // products per batch

  // Batch controller states.
  //   ST_ACC   : issuing open, products being accumulated
  //   ST_DRAIN : all operands issued, waiting for in-flight products
  //   ST_DONE  : sum complete, presented on the output handshake
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/binary_mul_valid_dly.sv
// -----------------------------------------------------------------------------
// binary_mul_valid_dly
// LATENCY-deep tag line that runs in lock-step with the multiplier pipeline.
// A 1 enters when an operand pair is accepted; the line only shifts when en=1
// so it freezes together with a stalled multiplier. tag_out is the last tap:
// when it is 1 and en=1, the product on P belongs to an accepted issue.
// -----------------------------------------------------------------------------
module binary_mul_valid_dly
  import binary_mul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tag_in,
  output logic tag_out
);

  logic [LATENCY-1:0] tags;

  if (LATENCY == 1) begin : g_single
    // Single-stage line: capture the accepted-issue flag on each enabled edge.
    always_ff @(posedge clk) begin
      // NOTE: the tag line is cleared on reset even though it looks like a
      // plain delay line -- stale 1s here would be counted as real products.
      if (rst) begin
        tags <= '0;
      end else if (en) begin
        tags <= tag_in;
      end
    end
  end else begin : g_multi
    // Multi-stage line: shift toward the output tap on each enabled edge.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment so every stage samples the pre-edge
      // value of its neighbour; blocking here would collapse the line.
      if (rst) begin
        tags <= '0;
      end else if (en) begin
        tags <= {tags[LATENCY-2:0], tag_in};
      end
    end
  end

  assign tag_out = tags[LATENCY-1];

endmodule

// File: rtl/binary_mul_acc_uni.sv
// -----------------------------------------------------------------------------
// binary_mul_acc_uni
// Downstream consumer of the 4x4 unsigned pipelined multiplier. Tags each
// accepted operand pair, accumulates N_TERMS products into one batch sum and
// presents the sum on a valid/ready handshake. in_ready throttles issue so a
// batch never issues more than N_TERMS operand pairs.
//
// Build option:
//   ACC_SAT_EN  defined   : on carry-out the sum clamps to 2^ACC_W-1 and stays
//                           there for the rest of the batch; ovf still sets.
//               undefined : the sum wraps mod 2^ACC_W; ovf flags the wrap.
// -----------------------------------------------------------------------------
module binary_mul_acc_uni
  import binary_mul_pkg::*;
#(
  parameter int P_W     = DEF_P_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             issue,
  output logic             in_ready,
  input  logic [P_W-1:0]   P,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  // Counters must be able to hold N_TERMS itself.
  localparam int             CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  acc_state_e       state, state_nxt;
  logic [CNT_W-1:0] iss_cnt, iss_nxt;
  logic [CNT_W-1:0] rcv_cnt, rcv_nxt;
  logic [ACC_W-1:0] acc_q, acc_nxt;
  logic             ovf_q, ovf_nxt;

  logic             accept;
  logic             tag_tap;
  logic             capture;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   p_ext;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == ST_ACC) && (iss_cnt < N_MAX);
  assign accept    = issue & en & in_ready;
  // A sum on display is frozen: nothing can be captured while in ST_DONE.
  assign capture   = tag_tap & en & (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  // Zero-extended product and the carry-out-capable sum.
  assign p_ext   = {{(ACC_W + 1 - P_W){1'b0}}, P};
  assign sum_ext = {1'b0, acc_q} + p_ext;

  // ---------------------------------------------------------------------------
  // Tag line tracking accepted issues through the multiplier latency
  // ---------------------------------------------------------------------------
  binary_mul_valid_dly #(
    .LATENCY (LATENCY)
  ) u_valid_dly (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .tag_in  (accept),
    .tag_out (tag_tap)
  );

  // Next-state, counter and accumulator update logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case/if tree leaves a value unassigned (no latches).
    state_nxt = state;
    iss_nxt   = iss_cnt;
    rcv_nxt   = rcv_cnt;
    acc_nxt   = acc_q;
    ovf_nxt   = ovf_q;

    if (accept) begin
      iss_nxt = iss_cnt + ONE;
    end

    if (capture) begin
      rcv_nxt = rcv_cnt + ONE;
      if (sum_ext[ACC_W]) begin
        ovf_nxt = 1'b1;
`ifdef ACC_SAT_EN
        // Clamp; a clamped sum plus any non-zero product carries again, so
        // the value stays pinned at full scale for the rest of the batch.
        acc_nxt = '1;
`else
        acc_nxt = sum_ext[ACC_W-1:0];
`endif
      end else begin
        acc_nxt = sum_ext[ACC_W-1:0];
      end
    end

    unique case (state)
      ST_ACC: begin
        if (iss_nxt == N_MAX) begin
          // The last capture may coincide with the last issue: skip DRAIN.
          state_nxt = (rcv_nxt == N_MAX) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rcv_nxt == N_MAX) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // out_valid is 1 here, so out_ready alone completes the handshake.
        if (out_ready) begin
          state_nxt = ST_ACC;
          iss_nxt   = '0;
          rcv_nxt   = '0;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // State, counter and accumulator registers; reset wins over every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      iss_cnt <= '0;
      rcv_cnt <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      iss_cnt <= iss_nxt;
      rcv_cnt <= rcv_nxt;
      acc_q   <= acc_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_binary_mul_acc_uni.sv
// -----------------------------------------------------------------------------
// tb_binary_mul_acc_uni
// Directed bench for binary_mul_acc_uni. Three instances share one clock:
//   u0 : N_TERMS=4, ACC_W=12   (basic batch, hold, en stall, reset)
//   u1 : N_TERMS=16, ACC_W=10  (overflow / saturation, honours ACC_SAT_EN)
//   u2 : defaults              (three random batches vs. a reference sum)
// Each instance is fed by a behavioural 4x4 multiplier with MUL_LATENCY stages.
// -----------------------------------------------------------------------------
module tb_binary_mul_acc_uni;
  import binary_mul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus.
  logic       rst       [3];
  logic       en        [3];
  logic       issue     [3];
  logic       out_ready [3];
  logic [3:0] op_a      [3];
  logic [3:0] op_b      [3];

  // Per-instance observations.
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       ovf       [3];
  logic [11:0] acc0;
  logic [9:0]  acc1;
  logic [11:0] acc2;

  // Behavioural multiplier pipelines.
  logic [7:0] pipe [3][MUL_LATENCY];

  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (en[u]) begin
        for (int s = MUL_LATENCY - 1; s > 0; s--) pipe[u][s] <= pipe[u][s-1];
        pipe[u][0] <= {4'b0, op_a[u]} * {4'b0, op_b[u]};
      end
    end
  end

  binary_mul_acc_uni #(.P_W(8), .ACC_W(12), .N_TERMS(4), .LATENCY(MUL_LATENCY)) u0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .issue(issue[0]), .in_ready(in_ready[0]),
    .P(pipe[0][MUL_LATENCY-1]), .acc_out(acc0), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ovf(ovf[0]));

  binary_mul_acc_uni #(.P_W(8), .ACC_W(10), .N_TERMS(16), .LATENCY(MUL_LATENCY)) u1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .issue(issue[1]), .in_ready(in_ready[1]),
    .P(pipe[1][MUL_LATENCY-1]), .acc_out(acc1), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ovf(ovf[1]));

  binary_mul_acc_uni u2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .issue(issue[2]), .in_ready(in_ready[2]),
    .P(pipe[2][MUL_LATENCY-1]), .acc_out(acc2), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .ovf(ovf[2]));

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] acc_of(input int u);
    case (u)
      0:       return 32'(acc0);
      1:       return 32'(acc1);
      default: return 32'(acc2);
    endcase
  endfunction

  // One clock: inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_issue(input int u, input int a, input int b);
    issue[u] = 1'b1;
    op_a[u]  = 4'(a);
    op_b[u]  = 4'(b);
    tick();
    issue[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, input int budget, input string tag);
    int n = 0;
    while (out_valid[u] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (out_valid[u] !== 1'b1) check({tag, "_timeout"}, 32'(out_valid[u]), 32'd1);
  endtask

  task automatic handshake(input int u, input string tag);
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid[u]), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready[u]), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic        no_ready;
    logic [31:0] model;
    logic        seen;
    logic        done;
    int          cyc;

    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; en[u] = 1'b1; issue[u] = 1'b0; out_ready[u] = 1'b0;
      op_a[u] = '0; op_b[u] = '0;
      for (int s = 0; s < MUL_LATENCY; s++) pipe[u][s] = '0;
    end
    tick();
    tick();
    for (int u = 0; u < 3; u++) rst[u] = 1'b0;

    // Reset state.
    check("rst_acc",       acc_of(0),          32'd0);
    check("rst_valid",     32'(out_valid[0]),  32'd0);
    check("rst_ovf",       32'(ovf[0]),        32'd0);
    check("rst_in_ready",  32'(in_ready[0]),   32'd1);
    check("rst_in_ready2", 32'(in_ready[2]),   32'd1);

    // Test 1: 3*5 + 2*2 + 15*15 + 0*7 = 244, issued back-to-back.
    do_issue(0, 3, 5);
    do_issue(0, 2, 2);
    do_issue(0, 15, 15);
    check("t1_ready_before_4th", 32'(in_ready[0]), 32'd1);
    do_issue(0, 0, 7);
    check("t1_ready_after_4th", 32'(in_ready[0]), 32'd0);
    for (int i = 0; i < MUL_LATENCY - 1; i++) tick();
    check("t1_valid_not_early", 32'(out_valid[0]), 32'd0);
    tick();
    check("t1_valid_on_time", 32'(out_valid[0]), 32'd1);
    check("t1_acc", acc_of(0), 32'd244);
    check("t1_ovf", 32'(ovf[0]), 32'd0);

    // Test 2: hold 10 cycles with issue asserted, then handshake.
    no_ready   = 1'b1;
    issue[0]   = 1'b1;
    op_a[0]    = 4'd15;
    op_b[0]    = 4'd15;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || acc_of(0) != 32'd244) no_ready = 1'b0;
    end
    issue[0] = 1'b0;
    check("t2_hold_stable", 32'(no_ready), 32'd1);
    check("t2_acc_held", acc_of(0), 32'd244);
    check("t2_ovf_held", 32'(ovf[0]), 32'd0);
    handshake(0, "t2");
    check("t2_acc_cleared", acc_of(0), 32'd0);
    for (int i = 0; i < MUL_LATENCY + 2; i++) tick();
    check("t2_no_stray_tags", acc_of(0), 32'd0);
    check("t2_idle_no_valid", 32'(out_valid[0]), 32'd0);

    // Test 4: en stall with two products in flight; stalled issue ignored.
    do_issue(0, 2, 3);
    do_issue(0, 4, 5);
    en[0]    = 1'b0;
    issue[0] = 1'b1;
    op_a[0]  = 4'd15;
    op_b[0]  = 4'd15;
    tick();
    issue[0] = 1'b0;
    tick();
    tick();
    check("t4_ready_in_stall", 32'(in_ready[0]), 32'd1);
    en[0] = 1'b1;
    do_issue(0, 6, 7);
    do_issue(0, 1, 9);
    wait_valid(0, 20, "t4");
    check("t4_acc", acc_of(0), 32'd77);
    check("t4_ovf", 32'(ovf[0]), 32'd0);
    handshake(0, "t4");

    // Test 5: reset with one product captured and three in flight.
    for (int i = 0; i < 4; i++) do_issue(0, 9, 9);
    tick();
    tick();
    check("t5_first_capture", acc_of(0), 32'd81);
    check("t5_draining", 32'(in_ready[0]), 32'd0);
    rst[0]       = 1'b1;
    out_ready[0] = 1'b1;
    tick();
    rst[0]       = 1'b0;
    out_ready[0] = 1'b0;
    check("t5_rst_acc", acc_of(0), 32'd0);
    check("t5_rst_valid", 32'(out_valid[0]), 32'd0);
    check("t5_rst_ready", 32'(in_ready[0]), 32'd1);
    for (int i = 0; i < MUL_LATENCY + 1; i++) tick();
    check("t5_no_stale", acc_of(0), 32'd0);
    for (int i = 0; i < 4; i++) do_issue(0, 1, 1);
    wait_valid(0, 20, "t5");
    check("t5_acc", acc_of(0), 32'd4);
    handshake(0, "t5");

    // Test 3: ACC_W=10, sixteen 15*15 products (3600).
    for (int i = 0; i < 16; i++) do_issue(1, 15, 15);
    check("t3_ready_closed", 32'(in_ready[1]), 32'd0);
    wait_valid(1, 20, "t3");
`ifdef ACC_SAT_EN
    check("t3_acc_sat", acc_of(1), 32'd1023);
`else
    check("t3_acc_wrap", acc_of(1), 32'd528);
`endif
    check("t3_ovf", 32'(ovf[1]), 32'd1);
    handshake(1, "t3");
    check("t3_ovf_cleared", 32'(ovf[1]), 32'd0);

    // Test 6: three default batches with random operands and out_ready.
    for (int bt = 0; bt < 3; bt++) begin
      model = '0;
      for (int i = 0; i < 16; i++) begin
        int a = $urandom_range(0, 15);
        int b = $urandom_range(0, 15);
        model += 32'(a * b);
        out_ready[2] = 1'($urandom_range(0, 1));
        do_issue(2, a, b);
      end
      seen = 1'b0;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 200) begin
        if (out_valid[2] === 1'b1 && !seen) begin
          check($sformatf("t6_b%0d_acc", bt), acc_of(2), model);
          check($sformatf("t6_b%0d_ovf", bt), 32'(ovf[2]), 32'd0);
          seen = 1'b1;
        end
        out_ready[2] = 1'($urandom_range(0, 1));
        done = (out_valid[2] === 1'b1) && out_ready[2];
        tick();
        cyc++;
      end
      out_ready[2] = 1'b0;
      check($sformatf("t6_b%0d_done", bt), 32'(done), 32'd1);
      check($sformatf("t6_b%0d_valid_drop", bt), 32'(out_valid[2]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
